// File: rtl/serial_max_finder_if.sv
// Stream and result handshake bundle for serial_max_finder.
// The slave modport is the finder's view; master is the driver/consumer side.
interface serial_max_finder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 2
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
  logic             busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_idx, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_idx, busy
  );
endinterface

// File: rtl/serial_max_finder.sv
// Frame maximum finder: one shared 2-bit slice comparator walks each new word
// against the running max from the MSB pair down, stopping at the first difference.
module serial_max_finder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4,
  parameter int unsigned IDX_W = 2
) (
  input logic               clk,
  input logic               rst_n,
  serial_max_finder_if.slave bus_io
);
  localparam int unsigned Slices = WIDTH / 2;
  localparam int unsigned PtrW   = (Slices > 1) ? $clog2(Slices) : 1;
  localparam int unsigned CntW   = $clog2(COUNT + 1);
  localparam logic [PtrW-1:0] MsbPtr  = PtrW'(Slices - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(COUNT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StCompare, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_max_q, out_max_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  // The single shared slice comparator.
  logic [1:0] cand_sl, max_sl;
  logic       sl_gt, sl_eq;

  assign cand_sl = cand_q[{ptr_q, 1'b0} +: 2];
  assign max_sl  = max_q[{ptr_q, 1'b0} +: 2];
  assign sl_gt   = cand_sl > max_sl;
  assign sl_eq   = cand_sl == max_sl;

  always_comb begin
    logic cmp_done;
    state_d   = state_q;
    max_d     = max_q;
    cand_d    = cand_q;
    idx_d     = idx_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    out_max_d = out_max_q;
    out_idx_d = out_idx_q;
    cmp_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StWait;
          count_d = '0;
        end
      end
      StWait: begin
        if (bus_io.in_valid) begin
          if (count_q == '0) begin
            max_d   = bus_io.in_data;
            idx_d   = '0;
            count_d = CntW'(1);
          end else begin
            cand_d  = bus_io.in_data;
            ptr_d   = MsbPtr;
            state_d = StCompare;
          end
        end
      end
      StCompare: begin
        if (sl_gt) begin
          max_d    = cand_q;
          idx_d    = IDX_W'(count_q);
          cmp_done = 1'b1;
        end else if (!sl_eq || ptr_q == '0) begin
          // Lower slice, or a full tie: the earlier index wins.
          cmp_done = 1'b1;
        end else begin
          ptr_d = ptr_q - PtrW'(1);
        end
        if (cmp_done) begin
          count_d = count_q + CntW'(1);
          if (count_q == LastCnt) begin
            state_d   = StDone;
            out_max_d = max_d;
            out_idx_d = idx_d;
          end else begin
            state_d = StWait;
          end
        end
      end
      StDone: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      max_q     <= '0;
      cand_q    <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      ptr_q     <= '0;
      out_max_q <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      cand_q    <= cand_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      out_max_q <= out_max_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StWait);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.out_max   = out_max_q;
  assign bus_io.out_idx   = out_idx_q;
endmodule

// File: tb/tb_serial_max_finder.sv
// Self-checking bench for serial_max_finder: directed vector table, hand-written
// backpressure and mid-compare reset sequences, and random frames against a model.
module tb_serial_max_finder;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  typedef logic [W-1:0] frame_t [N];

  typedef struct {
    string      name;
    frame_t     w;
    int         gap;
    int         hold;
    logic [W-1:0] exp_max;
    int         exp_idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_max_finder_if #(.WIDTH(W), .IDX_W(IW)) bus ();

  serial_max_finder #(.WIDTH(W), .COUNT(N), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare cycles = slice pairs examined until the first differing pair from the top.
  function automatic int cmp_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a ^ b;
    if (d == '0) return W / 2;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return W / 2 - i / 2;
    end
    return W / 2;
  endfunction

  task automatic run_frame(input string name, input frame_t w, input int gap, input int hold,
                           input logic [W-1:0] exp_max, input int exp_idx);
    logic [W-1:0] run_max;
    int cnt;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = w[0];
    check($sformatf("%s idle_in_ready", name), bus.in_ready, 0);
    tick();
    bus.start = 1'b0;
    check($sformatf("%s wait_in_ready", name), bus.in_ready, 1);
    run_max = w[0];
    for (int k = 0; k < N; k++) begin
      tick();
      if (k < N - 1) begin
        bus.in_data  = w[k+1];
        bus.in_valid = (gap == 0);
      end else begin
        bus.in_valid = 1'b0;
      end
      cnt = 0;
      while (!bus.in_ready && !bus.out_valid && cnt < 64) begin
        cnt++;
        tick();
      end
      check($sformatf("%s cmp_cycles%0d", name, k), cnt, (k == 0) ? 0 : cmp_cycles(w[k], run_max));
      if (w[k] > run_max) run_max = w[k];
      if (k < N - 1 && gap > 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check($sformatf("%s gap_ready%0d", name, k), bus.in_ready, 1);
        end
        bus.in_valid = 1'b1;
      end
    end
    check($sformatf("%s out_valid", name), bus.out_valid, 1);
    check($sformatf("%s out_max", name), bus.out_max, exp_max);
    check($sformatf("%s out_idx", name), bus.out_idx, exp_idx);
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      tick();
      check($sformatf("%s hold_valid%0d", name, h), bus.out_valid, 1);
      check($sformatf("%s hold_max%0d", name, h), bus.out_max, exp_max);
      check($sformatf("%s hold_idx%0d", name, h), bus.out_idx, exp_idx);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check($sformatf("%s post_valid", name), bus.out_valid, 0);
    check($sformatf("%s post_busy", name), bus.busy, 0);
    check($sformatf("%s post_max", name), bus.out_max, exp_max);
    tick();
    check($sformatf("%s idle_busy", name), bus.busy, 0);
  endtask

  vec_t vecs[4];
  frame_t rw;
  logic [W-1:0] rmax;
  int ridx;

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{"basic",  '{8'h12, 8'h80, 8'h7F, 8'h81}, 0, 0, 8'h81, 3};
    vecs[1] = '{"ties",   '{8'h55, 8'h55, 8'h10, 8'h55}, 0, 0, 8'h55, 0};
    vecs[2] = '{"zeros",  '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 3, 8'h00, 0};
    vecs[3] = '{"gaps",   '{8'h12, 8'h80, 8'h7F, 8'h81}, 2, 3, 8'h81, 3};

    #12;
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_max", bus.out_max, 0);
    check("reset out_idx", bus.out_idx, 0);
    check("reset busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].name, vecs[i].w, vecs[i].gap, vecs[i].hold,
                vecs[i].exp_max, vecs[i].exp_idx);
    end

    // Abort mid-COMPARE of word 2 after a nonzero result is already on the outputs.
    run_frame("preload", '{8'h10, 8'h20, 8'h30, 8'hC3}, 0, 0, 8'hC3, 3);
    bus.start = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("abort in_compare", bus.busy, 1);
    check("abort in_ready_low", bus.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", bus.out_valid, 0);
    check("abort out_max", bus.out_max, 0);
    check("abort out_idx", bus.out_idx, 0);
    check("abort busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort idle", bus.busy, 0);
    run_frame("after_reset", '{8'hFF, 8'h01, 8'h02, 8'h03}, 0, 0, 8'hFF, 0);

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) begin
        rw[k] = (r % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 3) * 85);
      end
      rmax = rw[0];
      ridx = 0;
      for (int k = 1; k < N; k++) begin
        if (rw[k] > rmax) begin
          rmax = rw[k];
          ridx = k;
        end
      end
      run_frame($sformatf("rand%0d", r), rw, $urandom_range(0, 2), $urandom_range(0, 2),
                rmax, ridx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
